// File: rtl/mux_nsel_scan.sv
// N-channel W-bit registered mux with manual select and auto-scan (DWELL samples per channel).
// Latency: 1 cycle from in/sel to out; out_vld is set on the capturing edge.
// Backpressure: out_vld && !out_rdy holds out/out_ch/sel_err and freezes the scan counters.
// Optional MUX_PARITY_EN adds out_par, the XOR reduction of the captured sample.
module mux_nsel_scan #(
    parameter int N     = 4,
    parameter int W     = 1,
    parameter int SELW  = 2,
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in,
    input  logic [SELW-1:0] sel,
    input  logic            mode,
    input  logic            en,
    output logic [W-1:0]    out,
    output logic [SELW-1:0] out_ch,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic            sel_err
`ifdef MUX_PARITY_EN
    ,
    output logic            out_par
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAN  = 2'd1,
        SCAN = 2'd2
    } state_t;

    // N always fits in SELW+1 bits because 2**SELW >= N
    localparam logic [SELW:0]   N_L      = (SELW+1)'(N);
    localparam logic [SELW-1:0] CH_LAST  = SELW'(N - 1);
    localparam logic [7:0]      DWELL_M1 = 8'(DWELL - 1);

    state_t          state;
    state_t          state_nxt;
    logic            cap;
    logic            man_bad;
    logic [W-1:0]    man_dat;
    logic [W-1:0]    scan_dat;
    logic [W-1:0]    cap_dat;
    logic [SELW-1:0] ch_cnt;
    logic [7:0]      dwell_cnt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: en gates everything, mode picks MAN or SCAN
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (en) state_nxt = mode ? SCAN : MAN;
            MAN: begin
                if (!en)      state_nxt = IDLE;
                else if (mode) state_nxt = SCAN;
            end
            SCAN: begin
                if (!en)       state_nxt = IDLE;
                else if (!mode) state_nxt = MAN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Channel muxes; an out-of-range select matches no channel and yields zero
    always_comb begin
        man_dat  = '0;
        scan_dat = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == SELW'(k))    man_dat  = in[k*W +: W];
            if (ch_cnt == SELW'(k)) scan_dat = in[k*W +: W];
        end
        man_bad = ({1'b0, sel} >= N_L);
        cap     = (state != IDLE) && (!out_vld || out_rdy);
        cap_dat = (state == SCAN) ? scan_dat : (man_bad ? '0 : man_dat);
    end

    // Output register: load on capture, drop valid when a sample drains while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out     <= '0;
            out_ch  <= '0;
            out_vld <= 1'b0;
            sel_err <= 1'b0;
        end else if (cap) begin
            out     <= cap_dat;
            out_ch  <= (state == SCAN) ? ch_cnt : sel;
            out_vld <= 1'b1;
            sel_err <= (state == MAN) && man_bad;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

`ifdef MUX_PARITY_EN
    // Parity of the captured sample, held alongside out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_par <= 1'b0;
        end else if (cap) begin
            out_par <= ^cap_dat;
        end
    end
`endif

    // Scan counters: cleared on entry to SCAN, advanced only by scan captures
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_cnt    <= '0;
            dwell_cnt <= '0;
        end else if (state != SCAN && state_nxt == SCAN) begin
            ch_cnt    <= '0;
            dwell_cnt <= '0;
        end else if (state == SCAN && cap) begin
            if (dwell_cnt == DWELL_M1) begin
                dwell_cnt <= '0;
                ch_cnt    <= (ch_cnt == CH_LAST) ? '0 : ch_cnt + 1'b1;
            end else begin
                dwell_cnt <= dwell_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mux_nsel_scan.sv
// Bench for mux_nsel_scan: two instances (N=4/W=1/DWELL=2 and N=3/W=4/DWELL=3)
// driven by shared controls, each checked every cycle against a sample-index model,
// plus directed checks for manual sweep, backpressure, scan order, mode switch, bad select, reset.
module tb_mux_nsel_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  in_a;
    logic [11:0] in_b;
    logic [1:0]  sel;
    logic        mode, en, rdy;
    logic        out_a;
    logic [3:0]  out_b;
    logic [1:0]  ch_a, ch_b;
    logic        vld_a, vld_b, err_a, err_b;
`ifdef MUX_PARITY_EN
    logic        par_a, par_b;
`endif

    int tests = 0;
    int fails = 0;

    localparam int MN[2] = '{4, 3};
    localparam int MW[2] = '{1, 4};
    localparam int MD[2] = '{2, 3};

    // Model state: st 0=idle 1=manual 2=scan; m_k counts scan samples since entry
    int m_st[2], m_k[2], m_vld[2], m_o[2], m_och[2], m_err[2];

    always #5 clk = ~clk;

    mux_nsel_scan #(.N(4), .W(1), .SELW(2), .DWELL(2)) u_a (
        .clk(clk), .rst(rst), .in(in_a), .sel(sel), .mode(mode), .en(en),
        .out(out_a), .out_ch(ch_a), .out_vld(vld_a), .out_rdy(rdy), .sel_err(err_a)
`ifdef MUX_PARITY_EN
        , .out_par(par_a)
`endif
    );

    mux_nsel_scan #(.N(3), .W(4), .SELW(2), .DWELL(3)) u_b (
        .clk(clk), .rst(rst), .in(in_b), .sel(sel), .mode(mode), .en(en),
        .out(out_b), .out_ch(ch_b), .out_vld(vld_b), .out_rdy(rdy), .sel_err(err_b)
`ifdef MUX_PARITY_EN
        , .out_par(par_b)
`endif
    );

    function automatic int field(longint v, int k, int w);
        return int'((v >> (k * w)) & ((longint'(1) << w) - 1));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_k[i] = 0; m_vld[i] = 0;
            m_o[i] = 0; m_och[i] = 0; m_err[i] = 0;
        end
    endtask

    task automatic model_step(int i, longint inv);
        bit cap;
        int ch;
        int nst;
        cap = (m_st[i] != 0) && (m_vld[i] == 0 || rdy);
        if (cap) begin
            if (m_st[i] == 1) begin
                m_och[i] = int'(sel);
                if (int'(sel) < MN[i]) begin
                    m_o[i] = field(inv, int'(sel), MW[i]);
                    m_err[i] = 0;
                end else begin
                    m_o[i] = 0;
                    m_err[i] = 1;
                end
            end else begin
                ch = (m_k[i] / MD[i]) % MN[i];
                m_o[i] = field(inv, ch, MW[i]);
                m_och[i] = ch;
                m_err[i] = 0;
                m_k[i]++;
            end
            m_vld[i] = 1;
        end else if (rdy) begin
            m_vld[i] = 0;
        end
        nst = !en ? 0 : (mode ? 2 : 1);
        if (nst == 2 && m_st[i] != 2) m_k[i] = 0;
        m_st[i] = nst;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a.vld", 64'(vld_a), 64'(m_vld[0]));
        chk("a.out", 64'(out_a), 64'(m_o[0]));
        chk("a.ch",  64'(ch_a),  64'(m_och[0]));
        chk("a.err", 64'(err_a), 64'(m_err[0]));
        chk("b.vld", 64'(vld_b), 64'(m_vld[1]));
        chk("b.out", 64'(out_b), 64'(m_o[1]));
        chk("b.ch",  64'(ch_b),  64'(m_och[1]));
        chk("b.err", 64'(err_b), 64'(m_err[1]));
`ifdef MUX_PARITY_EN
        chk("a.par", 64'(par_a), 64'(^m_o[0]));
        chk("b.par", 64'(par_b), 64'(^m_o[1]));
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            model_step(0, longint'(in_a));
            model_step(1, longint'(in_b));
        end
        #1;
        check_all();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got[$];
        int exp_seq[10];
        int budget;
        int n;
        exp_seq = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

        in_a = '0; in_b = '0; sel = '0; mode = 1'b0; en = 1'b0; rdy = 1'b1;
        rst = 1'b1;
        model_reset();
        #12;
        check_all();
        chk("rst.vld_a", 64'(vld_a), 64'd0);
        chk("rst.ch_a", 64'(ch_a), 64'd0);
        rst = 1'b0;

        // Manual select of channel 3
        en = 1'b1; mode = 1'b0; rdy = 1'b1; in_a = 4'b1000; sel = 2'd3; in_b = 12'($urandom);
        cyc();
        cyc();
        chk("man.out", 64'(out_a), 64'd1);
        chk("man.ch", 64'(ch_a), 64'd3);
        chk("man.vld", 64'(vld_a), 64'd1);

        // Sweep all patterns and selects
        for (int p = 0; p < 16; p++) begin
            for (int s = 0; s < 4; s++) begin
                in_a = 4'(p); sel = 2'(s); in_b = 12'($urandom);
                cyc();
                chk("sweep", 64'(out_a), 64'((p >> s) & 1));
            end
        end

        // Backpressure holds the pending sample
        in_a = 4'b0010; sel = 2'd1;
        cyc();
        chk("bp.cap", 64'(out_a), 64'd1);
        rdy = 1'b0; in_a = 4'b0000; sel = 2'd0;
        repeat (5) begin
            cyc();
            chk("bp.out", 64'(out_a), 64'd1);
            chk("bp.ch", 64'(ch_a), 64'd1);
            chk("bp.vld", 64'(vld_a), 64'd1);
        end
        rdy = 1'b1;
        cyc();
        chk("bp.rel.out", 64'(out_a), 64'd0);
        chk("bp.rel.ch", 64'(ch_a), 64'd0);

        // Drain to idle, then scan with a 3-cycle stall in the middle
        en = 1'b0;
        repeat (3) cyc();
        en = 1'b1; mode = 1'b1;
        budget = 0;
        while (got.size() < 10 && budget < 80) begin
            rdy = !(budget >= 6 && budget < 9);
            in_a = 4'($urandom); in_b = 12'($urandom);
            if (vld_a && rdy) got.push_back(int'(ch_a));
            cyc();
            budget++;
        end
        rdy = 1'b1;
        chk("scan.len", 64'(got.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < got.size()) chk("scan.seq", 64'(got[i]), 64'(exp_seq[i]));
        end

        // Mode switch at the first channel-2 sample
        n = 0;
        while (!(vld_a && ch_a == 2'd2) && n < 20) begin
            cyc();
            n++;
        end
        chk("msw.find", 64'(ch_a), 64'd2);
        mode = 1'b0; sel = 2'd1;
        cyc();
        chk("msw.old", 64'(ch_a), 64'd2);
        cyc();
        chk("msw.man", 64'(ch_a), 64'd1);
        mode = 1'b1;
        cyc();
        cyc();
        chk("msw.rescan", 64'(ch_a), 64'd0);

        // Out-of-range select on the 3-channel instance
        mode = 1'b0; sel = 2'd3; in_b = 12'hFFF;
        cyc();
        cyc();
        chk("bad.out", 64'(out_b), 64'd0);
        chk("bad.ch", 64'(ch_b), 64'd3);
        chk("bad.err", 64'(err_b), 64'd1);
        chk("bad.vld", 64'(vld_b), 64'd1);
        sel = 2'd0; in_b = 12'h007;
        cyc();
        chk("bad.clr", 64'(err_b), 64'd0);
        chk("bad.ok", 64'(out_b), 64'd7);
`ifdef MUX_PARITY_EN
        chk("par.0111", 64'(par_b), 64'd1);
`endif

        // Randomised mix of modes, enables and backpressure
        repeat (400) begin
            in_a = 4'($urandom); in_b = 12'($urandom); sel = 2'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            cyc();
        end

        // Asynchronous reset while a scan sample is pending
        en = 1'b1; mode = 1'b1; rdy = 1'b1;
        repeat (4) cyc();
        rdy = 1'b0;
        cyc();
        chk("arst.pre", 64'(vld_a), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst.vld_a", 64'(vld_a), 64'd0);
        chk("arst.out_a", 64'(out_a), 64'd0);
        chk("arst.ch_a", 64'(ch_a), 64'd0);
        chk("arst.vld_b", 64'(vld_b), 64'd0);
        model_reset();
        #2;
        rst = 1'b0;
        rdy = 1'b1;
        cyc();
        cyc();
        chk("arst.first.vld", 64'(vld_a), 64'd1);
        chk("arst.first.ch", 64'(ch_a), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_nsel_scan.md
Name: mux_nsel_scan

Overview:
Parametrised N-channel, W-bit registered multiplexer and successor to the 4-to-1 single-bit mux. It supports two modes:
- Manual: software-style select.
- Auto-scan: an internal counter steps through every channel, dwelling DWELL samples on each.
The output is a registered valid/ready stream, so it can feed downstream sampling or serialising logic with backpressure.

Parameters:
N, 4, number of input channels (2..16)
W, 1, data width per channel in bits
SELW, 2, select/channel index width; must satisfy 2**SELW >= N
DWELL, 4, accepted samples per channel in scan mode before advancing (1..255)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in  input  N*W  packed channel data; channel k occupies bits [k*W+W-1 : k*W]
sel  input  SELW  manual-mode channel select
mode  input  1  0 = manual, 1 = auto-scan
en  input  1  enable sampling; 0 = idle
out  output  W  registered selected data
out_ch  output  SELW  channel index that produced out
out_vld  output  1  out/out_ch hold a valid sample
out_rdy  input  1  downstream accepts sample when out_vld && out_rdy
sel_err  output  1  registered; 1 when last manual capture used sel >= N

Behaviour:
- Reset (async, immediate): out=0, out_ch=0, out_vld=0, sel_err=0, scan channel counter=0, dwell counter=0, FSM=IDLE.
- Capture condition: cap = (state != IDLE) && (!out_vld || out_rdy). When cap is true, the output register loads on that edge. Latency is 1 cycle from input to out.
- Backpressure: when out_vld && !out_rdy, out, out_ch and sel_err are held stable and the scan/dwell counters do not advance.
- When out_rdy && out_vld and no capture occurs (state IDLE), out_vld clears to 0 on that edge. out keeps its last value.
- FSM states:
  - IDLE: next state = !en ? IDLE : (mode ? SCAN : MAN).
  - MAN: leaves when !en (to IDLE) or mode=1 (to SCAN).
  - SCAN: leaves when !en (to IDLE) or mode=0 (to MAN).
  - State transitions take effect on the next edge. The capture in the current cycle uses the current state.
- MAN capture: out = in[sel], out_ch = sel, sel_err = 0.
  - If sel >= N: out = 0, out_ch = sel, sel_err = 1, and out_vld still asserts.
- SCAN capture: out = in[ch_cnt], out_ch = ch_cnt, sel_err = 0, then dwell_cnt increments.
  - When dwell_cnt reaches DWELL-1 on a capture: dwell_cnt goes to 0 and ch_cnt advances.
  - ch_cnt wraps from N-1 to 0.
- Entering SCAN from IDLE or MAN resets ch_cnt=0 and dwell_cnt=0 on the transition edge.
  - The first scan sample is therefore channel 0 with a full dwell.
- Leaving SCAN freezes the counters. They are cleared again on re-entry.
- Simultaneous events:
  - A pending sample (out_vld=1) is never dropped by a mode change or by en=0; it remains until accepted.
  - A mode change in the same cycle as cap uses the old mode for that capture.
- rst mid-stream discards any pending sample immediately (out_vld=0 asynchronously).

Optional Feature:
MUX_PARITY_EN
- Defined: adds output port out_par (1 bit), registered alongside out. out_par = even parity (XOR reduction) of the captured W bits. Reset value 0. Held under backpressure exactly like out.
- Not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- N=4, W=1, manual: out_rdy=1, en=1, mode=0, in=4'b1000, sel=3 -> one cycle later out=1, out_ch=3, out_vld=1, sel_err=0. Sweep all 16 in patterns x 4 sel values; out == in[sel] every cycle.
- Backpressure: capture in=4'b0010 with sel=1 (out=1), then drop out_rdy=0 and change in=0, sel=0 for 5 cycles -> out=1, out_ch=1, out_vld=1 held. Raise out_rdy -> next cycle out=0, out_ch=0.
- Scan: N=4, DWELL=2, out_rdy=1, mode=1 -> out_ch sequence 0,0,1,1,2,2,3,3,0,0. Insert out_rdy=0 for 3 cycles mid-sequence -> sequence unchanged, no skips or repeats.
- Mode switch: in SCAN at ch_cnt=2, set mode=0, sel=1 -> next capture still ch 2, then ch 1. Return to mode=1 -> scan restarts at ch 0.
- Bad select: N=3, SELW=2, sel=3 -> out=0, out_ch=3, sel_err=1. Then sel=0 -> sel_err=0.
- Reset mid-operation: assert rst asynchronously between edges while out_vld=1 in SCAN -> out_vld=0, out=0, out_ch=0 immediately. After release with en=1, mode=1 -> first sample from ch 0. With MUX_PARITY_EN, W=4, in channel value 4'b0111 -> out_par=1.
